// File: rtl/mem_pkg.sv
// Shared constants and types for the dual-bank memory front end.
//   DATA_W   : memory word width
//   BANK_AW  : per-bank word address width
//   CPU_AW   : CPU address width; the extra top bit selects the bank
//   state_t  : controller FSM states
//   BANK_BOT / BANK_TOP : values of the bank-select bit
package mem_pkg;

    localparam int DATA_W  = 20;
    localparam int BANK_AW = 15;
    localparam int CPU_AW  = BANK_AW + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,  // free for a new request
        RD_CAP = 2'd1,  // bank read issued last edge; bank do valid now
        RSP    = 2'd2   // response held until rsp_ready
    } state_t;

    localparam logic BANK_BOT = 1'b0;
    localparam logic BANK_TOP = 1'b1;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// CPU-side request/response bus of the memory front end.
//   req_valid/req_ready/req_we/req_addr/req_wdata : request channel
//   rsp_valid/rsp_ready/rsp_rdata                 : load response channel
// Modports: master = CPU side, slave = controller side.
interface mem_access_ctrl_if;
    import mem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [CPU_AW-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/mem_access_ctrl.sv
// Front end for two 32K x 20 synchronous memory banks (bottom, top).
// Accepts single load/store requests on a valid/ready handshake, steers each
// to a bank with address bit 15, captures the 1-cycle registered read data
// and returns it on a held valid/ready response channel.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   bus (slave)           : CPU request/response channel
//   bot_addr/di/we/re/do  : bottom-bank interface (do is registered by the bank)
//   top_addr/di/we/re/do  : top-bank interface
module mem_access_ctrl
    import mem_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    mem_access_ctrl_if.slave    bus,
    output logic [BANK_AW-1:0]  bot_addr,
    output logic [DATA_W-1:0]   bot_di,
    output logic                bot_we,
    output logic                bot_re,
    input  logic [DATA_W-1:0]   bot_do,
    output logic [BANK_AW-1:0]  top_addr,
    output logic [DATA_W-1:0]   top_di,
    output logic                top_we,
    output logic                top_re,
    input  logic [DATA_W-1:0]   top_do
);

    state_t            state, next_state;
    logic              sel_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              accept;
    logic              sel;

    // Address and write data go to both banks unconditionally; only the
    // strobes decide which bank acts.
    assign bot_addr = bus.req_addr[BANK_AW-1:0];
    assign top_addr = bus.req_addr[BANK_AW-1:0];
    assign bot_di   = bus.req_wdata;
    assign top_di   = bus.req_wdata;

    assign sel = bus.req_addr[CPU_AW-1];

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        bus.req_ready = (state == IDLE) || ((state == RSP) && bus.rsp_ready);
        // rst_n gates the accept so the bank strobes are low for the whole
        // reset period even though the state reads IDLE.
        accept        = bus.req_valid && bus.req_ready && rst_n;
        next_state    = state;
        bot_we        = 1'b0;
        bot_re        = 1'b0;
        top_we        = 1'b0;
        top_re        = 1'b0;

        if (accept) begin
            if (sel == BANK_TOP) begin
                top_we = bus.req_we;
                top_re = !bus.req_we;
            end else begin
                bot_we = bus.req_we;
                bot_re = !bus.req_we;
            end
        end

        unique case (state)
            IDLE: begin
                if (accept && !bus.req_we) next_state = RD_CAP;
            end
            RD_CAP: begin
                next_state = RSP;
            end
            RSP: begin
                // A request taken while the old response retires chains
                // straight on: a load re-enters RD_CAP, a store frees us.
                if (bus.rsp_ready) begin
                    next_state = (accept && !bus.req_we) ? RD_CAP : IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q       <= BANK_BOT;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            if (accept && !bus.req_we) begin
                sel_q <= sel;
            end

            if (state == RD_CAP) begin
                // The bank's registered do is valid exactly one edge after
                // the read strobe was sampled.
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= (sel_q == BANK_TOP) ? top_do : bot_do;
            end else if ((state == RSP) && bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl with behavioural
// bottom/top memory banks (registered read data) behind the controller.
module tb_mem_access_ctrl;
    import mem_pkg::*;

    logic clk;
    logic rst_n;

    mem_access_ctrl_if bus ();

    logic [BANK_AW-1:0] bot_addr, top_addr;
    logic [DATA_W-1:0]  bot_di, top_di, bot_do, top_do;
    logic               bot_we, bot_re, top_we, top_re;

    mem_access_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .bot_addr (bot_addr),
        .bot_di   (bot_di),
        .bot_we   (bot_we),
        .bot_re   (bot_re),
        .bot_do   (bot_do),
        .top_addr (top_addr),
        .top_di   (top_di),
        .top_we   (top_we),
        .top_re   (top_re),
        .top_do   (top_do)
    );

    // Behavioural banks: synchronous write, registered read.
    // NOTE: memory arrays are never reset; only words written by the test are read.
    logic [DATA_W-1:0] bot_mem [0:(1<<BANK_AW)-1];
    logic [DATA_W-1:0] top_mem [0:(1<<BANK_AW)-1];

    always @(posedge clk) begin
        if (bot_we) bot_mem[bot_addr] <= bot_di;
        if (bot_re) bot_do <= bot_mem[bot_addr];
        if (top_we) top_mem[top_addr] <= top_di;
        if (top_re) top_do <= top_mem[top_addr];
    end

    // Edges on which each bank saw any strobe.
    int bot_strobes = 0;
    int top_strobes = 0;
    always @(posedge clk) begin
        if (bot_we || bot_re) bot_strobes <= bot_strobes + 1;
        if (top_we || top_re) top_strobes <= top_strobes + 1;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic any_strobe();
        return bot_we | bot_re | top_we | top_re;
    endfunction

    // Present a request at a negedge, wait (bounded) for req_ready, and
    // return #1 after the accept edge with req_valid dropped.
    task automatic issue(input logic we, input logic [15:0] addr, input logic [19:0] data,
                         input string tag);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = data;
        #1;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 20) check({tag, "_accept_timeout"}, 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    // Called #1 after the accept edge of a load: the response must appear
    // after exactly one further edge (two edges counting the accept edge).
    task automatic wait_rsp(input logic [19:0] exp, input string tag);
        int n = 0;
        while (!bus.rsp_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd1);
        check({tag, "_rdata"}, 32'(bus.rsp_rdata), 32'(exp));
    endtask

    // Full load with rsp_ready already high; ends back in IDLE at a negedge.
    task automatic load(input logic [15:0] addr, input logic [19:0] exp, input string tag);
        issue(1'b0, addr, '0, tag);
        check({tag, "_rd_cap_valid"}, 32'(bus.rsp_valid), 32'd0);
        wait_rsp(exp, tag);
        @(posedge clk);
        #1;
        check({tag, "_retired"}, 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
    endtask

    int t0;

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 16'h0010;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;

        // 1 Reset with a pending load request: no strobes, no response.
        repeat (3) begin
            @(negedge clk);
            check("rst_strobes", 32'(any_strobe()), 32'd0);
            check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        end
        check("rst_rdata", 32'(bus.rsp_rdata), 32'd0);
        bus.req_valid = 1'b0;
        rst_n         = 1'b1;
        @(negedge clk);
        check("idle_req_ready", 32'(bus.req_ready), 32'd1);

        // 2 Store then load, bottom bank; top bank untouched.
        t0 = top_strobes;
        issue(1'b1, 16'h0010, 20'h12345, "st_bot");
        check("st_no_rsp", 32'(bus.rsp_valid), 32'd0);
        check("st_req_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        load(16'h0010, 20'h12345, "ld_bot");
        check("bot_top_untouched", 32'(top_strobes - t0), 32'd0);

        // 3 Bank boundary: 0x7FFF is bottom word 0x7FFF, 0x8000 is top word 0.
        issue(1'b1, 16'h7FFF, 20'hAAAAA, "st_7fff");
        @(negedge clk);
        issue(1'b1, 16'h8000, 20'h55555, "st_8000");
        @(negedge clk);
        check("bot_mem_7fff", 32'(bot_mem[15'h7FFF]), 32'h000AAAAA);
        check("top_mem_0", 32'(top_mem[15'h0000]), 32'h00055555);
        load(16'h7FFF, 20'hAAAAA, "ld_7fff");
        load(16'h8000, 20'h55555, "ld_8000");

        // 4 Backpressure: response held for 5 cycles, no requests taken.
        bus.rsp_ready = 1'b0;
        issue(1'b0, 16'h0010, '0, "bp");
        wait_rsp(20'h12345, "bp");
        t0 = bot_strobes + top_strobes;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 16'h0020;
        bus.req_wdata = 20'h0F0F0;
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_rdata", 32'(bus.rsp_rdata), 32'h00012345);
            check("bp_req_ready", 32'(bus.req_ready), 32'd0);
            check("bp_strobe", 32'(any_strobe()), 32'd0);
        end
        check("bp_strobe_count", 32'((bot_strobes + top_strobes) - t0), 32'd0);
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_retired", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);

        // 5 Zero-bubble: retire a held response and accept a load on one edge.
        issue(1'b1, 16'h8001, 20'h0ABCD, "st_8001");
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        issue(1'b0, 16'h0010, '0, "zb_first");
        wait_rsp(20'h12345, "zb_first");
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 16'h8001;
        #1;
        check("zb_req_ready", 32'(bus.req_ready), 32'd1);
        check("zb_top_re", 32'(top_re), 32'd1);
        check("zb_bot_re", 32'(bot_re), 32'd0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("zb_bubble", 32'(bus.rsp_valid), 32'd0);
        wait_rsp(20'h0ABCD, "zb_second");
        @(posedge clk);
        #1;
        check("zb_retired", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);

        // 6 Reset while in RD_CAP: response discarded.
        issue(1'b0, 16'h8000, '0, "rst_mid");
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(bus.rsp_valid), 32'd0);
        repeat (2) @(negedge clk);
        check("rst_mid_strobes", 32'(any_strobe()), 32'd0);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_mid_no_stale", 32'(bus.rsp_valid), 32'd0);
        end
        check("rst_mid_idle", 32'(bus.req_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
